// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from NUM_REQ sources into a single uart
// transmitter, with start-handshake timeout and optional idle gap between bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ID_WIDTH      = 1,
    parameter int START_TIMEOUT = 5000,
    parameter int TO_WIDTH      = 13,
    parameter int GAP_CYCLES    = 0,
    parameter int GAP_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   transmit,
    output logic [7:0]             tx_byte,
    input  logic                   is_transmitting,
    output logic                   busy,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   sent,
    output logic                   timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(START_TIMEOUT - 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LAST  = GAP_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_WIDTH-1:0]  LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    logic [1:0]           state;
    logic [ID_WIDTH-1:0]  last;
    logic [TO_WIDTH-1:0]  to_cnt;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [ID_WIDTH-1:0]  pick;

    // First valid requester after the previous winner, wrapping modulo NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                    input logic [ID_WIDTH-1:0] l);
        logic [ID_WIDTH-1:0] sel;
        logic                found;
        int                  idx;
        sel   = l;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(l) + k) % NUM_REQ;
            if (!found && ((v & (NUM_REQ'(1) << idx)) != '0)) begin
                sel   = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req_valid, last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last        <= LAST_INIT;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            req_ready   <= '0;
            transmit    <= 1'b0;
            tx_byte     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            sent        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= '0;
            sent        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        req_ready <= NUM_REQ'(1) << pick;
                        tx_byte   <= 8'(req_data >> {pick, 3'b000});
                        grant_id  <= pick;
                        last      <= pick;
                        transmit  <= 1'b1;
                        busy      <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    // A late uart start on the timeout cycle still counts as a start.
                    if (is_transmitting) begin
                        transmit <= 1'b0;
                        state    <= S_SEND;
                    end else if (to_cnt == TO_LAST) begin
                        transmit    <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (!is_transmitting) begin
                        sent <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    transmit <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap / 10-cycle gap) each driven against a
// behavioural uart that raises is_transmitting one cycle after transmit and holds it 100 cycles.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  a_valid = '0;
    logic [15:0] a_data = '0;
    logic [1:0]  a_ready;
    logic        a_transmit;
    logic [7:0]  a_tx_byte;
    logic        a_is_tx;
    logic        a_busy;
    logic [0:0]  a_grant;
    logic        a_sent;
    logic        a_to;
    logic        a_never = 1'b0;
    int          a_hold;
    logic [7:0]  a_cap[$];

    logic [1:0]  g_valid = '0;
    logic [15:0] g_data = '0;
    logic [1:0]  g_ready;
    logic        g_transmit;
    logic [7:0]  g_tx_byte;
    logic        g_is_tx;
    logic        g_busy;
    logic [0:0]  g_grant;
    logic        g_sent;
    logic        g_to;
    int          g_hold;
    logic [7:0]  g_cap[$];

    uart_tx_arbiter #(.NUM_REQ(2), .ID_WIDTH(1), .START_TIMEOUT(16), .TO_WIDTH(13),
                      .GAP_CYCLES(0), .GAP_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .transmit(a_transmit), .tx_byte(a_tx_byte), .is_transmitting(a_is_tx), .busy(a_busy),
        .grant_id(a_grant), .sent(a_sent), .timeout_err(a_to));

    uart_tx_arbiter #(.NUM_REQ(2), .ID_WIDTH(1), .START_TIMEOUT(16), .TO_WIDTH(13),
                      .GAP_CYCLES(10), .GAP_WIDTH(8)) u_gap (
        .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data), .req_ready(g_ready),
        .transmit(g_transmit), .tx_byte(g_tx_byte), .is_transmitting(g_is_tx), .busy(g_busy),
        .grant_id(g_grant), .sent(g_sent), .timeout_err(g_to));

    // Uart stand-ins: log each byte the moment a frame starts.
    always @(posedge clk) begin
        if (rst) begin
            a_is_tx <= 1'b0;
            a_hold  <= 0;
        end else if (a_never) begin
            a_is_tx <= 1'b0;
        end else if (a_hold != 0) begin
            a_hold <= a_hold - 1;
            if (a_hold == 1) a_is_tx <= 1'b0;
        end else if (a_transmit) begin
            a_is_tx <= 1'b1;
            a_hold  <= 100;
            a_cap.push_back(a_tx_byte);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            g_is_tx <= 1'b0;
            g_hold  <= 0;
        end else if (g_hold != 0) begin
            g_hold <= g_hold - 1;
            if (g_hold == 1) g_is_tx <= 1'b0;
        end else if (g_transmit) begin
            g_is_tx <= 1'b1;
            g_hold  <= 100;
            g_cap.push_back(g_tx_byte);
        end
    end

    // Round-robin rule: scan last+1, last+2, ... modulo 2 and take the first requester present.
    function automatic logic [0:0] rr_expect(input logic [1:0] v, input logic [0:0] l);
        logic [0:0] c;
        for (int k = 1; k <= 2; k++) begin
            c = 1'((int'(l) + k) % 2);
            if (v[c]) return c;
        end
        return l;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = '0;
        g_valid = '0;
        a_never = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a_cap.delete();
        g_cap.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        a_valid = 2'b11;
        a_data  = 16'hB1A0;
        g_valid = 2'b11;
        g_data  = 16'h2211;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_ready, a_transmit, a_tx_byte, a_busy, a_grant, a_sent, a_to} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs_a got %h exp 0",
                         {a_ready, a_transmit, a_tx_byte, a_busy, a_grant, a_sent, a_to});
            end
            checks++;
            if ({g_ready, g_transmit, g_tx_byte, g_busy, g_grant, g_sent, g_to} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs_g got %h exp 0",
                         {g_ready, g_transmit, g_tx_byte, g_busy, g_grant, g_sent, g_to});
            end
        end
        a_valid = '0;
        g_valid = '0;
        rst     = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy=%b ready=%b exp 0/00", a_busy, a_ready);
        end
    endtask

    task automatic test_single();
        int tx_cycles;
        int n;
        do_reset();
        a_data  = 16'h0041;
        a_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", a_ready); end
        checks++;
        if (a_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte got %h exp 41", a_tx_byte); end
        checks++;
        if (a_transmit !== 1'b1 || a_busy !== 1'b1) begin
            errors++; $display("FAIL single_start got tx=%b busy=%b exp 1/1", a_transmit, a_busy);
        end
        checks++;
        if (a_grant !== 1'b0) begin errors++; $display("FAIL single_grant got %0d exp 0", a_grant); end
        a_valid   = 2'b00;
        tx_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_transmit) break;
            tx_cycles++;
        end
        checks++;
        if (tx_cycles !== 2) begin errors++; $display("FAIL single_tx_len got %0d exp 2", tx_cycles); end
        n = 0;
        while (!a_sent && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_sent !== 1'b1) begin errors++; $display("FAIL single_sent got %b exp 1 (no pulse in 300 cycles)", a_sent); end
        checks++;
        if (a_is_tx !== 1'b0 || n < 100) begin
            errors++; $display("FAIL single_sent_timing got is_tx=%b wait=%0d exp 0 and >=100", a_is_tx, n);
        end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", a_busy); end
        @(negedge clk);
        checks++;
        if (a_sent !== 1'b0) begin errors++; $display("FAIL single_sent_pulse got %b exp 0", a_sent); end
        checks++;
        if (a_cap.size() !== 1 || a_cap[0] !== 8'h41) begin
            errors++; $display("FAIL single_line got n=%0d b=%h exp 1/41", a_cap.size(), a_cap[0]);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_f[4];
        int sents;
        int readies;
        int n;
        exp_f   = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
        do_reset();
        a_data  = 16'hB1A0;
        a_valid = 2'b11;
        sents   = 0;
        readies = 0;
        n       = 0;
        while (sents < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            checks++;
            if ($countones(a_ready) > 1) begin
                errors++; $display("FAIL fair_onehot got %b exp at most one bit", a_ready);
            end
            if (a_ready != 2'b00) readies++;
            if (a_sent) sents++;
        end
        a_valid = 2'b00;
        checks++;
        if (sents !== 4) begin errors++; $display("FAIL fair_sent got %0d exp 4", sents); end
        checks++;
        if (readies !== 4) begin errors++; $display("FAIL fair_ready_count got %0d exp 4", readies); end
        checks++;
        if (a_cap.size() !== 4) begin errors++; $display("FAIL fair_bytes got %0d exp 4", a_cap.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < a_cap.size()) begin
                checks++;
                if (a_cap[i] !== exp_f[i]) begin
                    errors++; $display("FAIL fair_order[%0d] got %h exp %h", i, a_cap[i], exp_f[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        int tos;
        int snt;
        int n;
        do_reset();
        a_never = 1'b1;
        a_data  = {8'h77, 8'($urandom)};
        a_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b01 || a_transmit !== 1'b1) begin
            errors++; $display("FAIL to_accept got ready=%b tx=%b exp 01/1", a_ready, a_transmit);
        end
        a_valid = 2'b10;
        hi  = 1;
        tos = 0;
        snt = 0;
        n   = 0;
        while (a_transmit && n < 100) begin
            @(negedge clk);
            n++;
            if (a_to) tos++;
            if (a_sent) snt++;
            if (a_transmit) hi++;
        end
        checks++;
        if (hi !== 16) begin errors++; $display("FAIL to_tx_len got %0d exp 16", hi); end
        checks++;
        if (a_to !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL to_pulse got err=%b busy=%b exp 1/0", a_to, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_to !== 1'b0 || tos !== 1) begin
            errors++; $display("FAIL to_once got err=%b count=%0d exp 0/1", a_to, tos);
        end
        checks++;
        if (snt !== 0 || a_sent !== 1'b0) begin errors++; $display("FAIL to_no_sent got %0d exp 0", snt); end
        checks++;
        if (a_ready !== 2'b10 || a_transmit !== 1'b1 || a_tx_byte !== 8'h77) begin
            errors++; $display("FAIL to_rearb got ready=%b tx=%b byte=%h exp 10/1/77",
                               a_ready, a_transmit, a_tx_byte);
        end
        a_valid = 2'b00;
        a_never = 1'b0;
    endtask

    task automatic test_gap();
        int n;
        int idle;
        do_reset();
        g_data  = {8'($urandom), 8'($urandom)};
        g_valid = 2'b11;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            while (!g_sent && n < 300) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (g_sent !== 1'b1 || g_busy !== 1'b1) begin
                errors++; $display("FAIL gap_sent[%0d] got sent=%b busy=%b exp 1/1", b, g_sent, g_busy);
            end
            idle = 0;
            @(negedge clk);
            while (!g_transmit && idle < 50) begin
                idle++;
                checks++;
                if (g_ready !== 2'b00) begin
                    errors++; $display("FAIL gap_ready got %b exp 00", g_ready);
                end
                @(negedge clk);
            end
            checks++;
            if (idle !== 10) begin errors++; $display("FAIL gap_idle[%0d] got %0d exp 10", b, idle); end
        end
        g_valid = 2'b00;
        checks++;
        if (g_cap.size() < 2 || g_cap[0] !== g_data[7:0] || g_cap[1] !== g_data[15:8]) begin
            errors++; $display("FAIL gap_order got n=%0d %h %h exp %h %h", g_cap.size(),
                               g_cap[0], g_cap[1], g_data[7:0], g_data[15:8]);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        a_data  = 16'hC35A;
        a_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b01) begin errors++; $display("FAIL mid_accept got %b exp 01", a_ready); end
        a_valid = 2'b10;
        repeat (5) @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_is_tx !== 1'b1 || a_transmit !== 1'b0) begin
            errors++; $display("FAIL mid_in_send got busy=%b is_tx=%b tx=%b exp 1/1/0",
                               a_busy, a_is_tx, a_transmit);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_transmit !== 1'b0 || a_busy !== 1'b0 || a_ready !== 2'b00 || a_tx_byte !== 8'h00) begin
            errors++; $display("FAIL mid_reset got tx=%b busy=%b ready=%b byte=%h exp 0/0/00/00",
                               a_transmit, a_busy, a_ready, a_tx_byte);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b10 || a_transmit !== 1'b1 || a_tx_byte !== 8'hC3 || a_grant !== 1'b1) begin
            errors++; $display("FAIL mid_reaccept got ready=%b tx=%b byte=%h grant=%0d exp 10/1/c3/1",
                               a_ready, a_transmit, a_tx_byte, a_grant);
        end
        a_valid = 2'b00;
    endtask

    task automatic test_random();
        logic       vld[2];
        logic [7:0] dat[2];
        logic [7:0] acc[$];
        logic [0:0] last_m;
        logic [0:0] w;
        logic [0:0] r;
        logic [7:0] exp_b;
        int         accepted;
        int         sents;
        do_reset();
        vld      = '{1'b0, 1'b0};
        dat      = '{8'h00, 8'h00};
        last_m   = 1'b1;
        accepted = 0;
        sents    = 0;
        for (int cyc = 0; cyc < 4000 && accepted < 14; cyc++) begin
            @(negedge clk);
            if (a_sent) sents++;
            if (a_ready !== 2'b00) begin
                w     = rr_expect(a_valid, last_m);
                exp_b = w ? a_data[15:8] : a_data[7:0];
                checks++;
                if (a_ready !== (w ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rnd_winner got %b valid=%b last=%0d", a_ready, a_valid, last_m);
                end
                checks++;
                if (a_tx_byte !== exp_b || a_grant !== w || a_transmit !== 1'b1) begin
                    errors++; $display("FAIL rnd_accept got byte=%h grant=%0d tx=%b exp %h/%0d/1",
                                       a_tx_byte, a_grant, a_transmit, exp_b, w);
                end
                acc.push_back(exp_b);
                last_m = w;
                accepted++;
                vld[w] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                r = 1'(i);
                if (!vld[r] && $urandom_range(7) == 0) begin
                    vld[r] = 1'b1;
                    dat[r] = 8'($urandom);
                end else if (vld[r] && $urandom_range(63) == 0) begin
                    vld[r] = 1'b0;
                end
            end
            a_valid = {vld[1], vld[0]};
            a_data  = {dat[1], dat[0]};
        end
        a_valid = 2'b00;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (a_sent) sents++;
            checks++;
            if (a_ready !== 2'b00) begin errors++; $display("FAIL rnd_drain_ready got %b exp 00", a_ready); end
        end
        checks++;
        if (accepted < 1 || sents !== accepted) begin
            errors++; $display("FAIL rnd_sent_count got %0d exp %0d", sents, accepted);
        end
        checks++;
        if (a_cap.size() !== acc.size()) begin
            errors++; $display("FAIL rnd_line_count got %0d exp %0d", a_cap.size(), acc.size());
        end else begin
            for (int i = 0; i < acc.size(); i++) begin
                checks++;
                if (a_cap[i] !== acc[i]) begin
                    errors++; $display("FAIL rnd_line[%0d] got %h exp %h", i, a_cap[i], acc[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_gap();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
